scoreboard_hashmap: RTL and testbench



---
 rtl/scoreboard_hashmap_if.sv | 38 +++
 rtl/scoreboard_hashmap.sv | 177 +++++++++++++++++
 tb/tb_scoreboard_hashmap.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/scoreboard_hashmap_if.sv
`default_nettype none
// ============================================================================
// Module      : scoreboard_hashmap_if
// Description : Request/response bundle for the scoreboard hash map.
//               The slave modport is the table side, the master modport is
//               the issuer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface scoreboard_hashmap_if #(
    parameter int DEPTH = 8,
    parameter int KEY_W = 8,
    parameter int VAL_W = 3
);
    localparam int IDX_W = $clog2(DEPTH);

    logic               i_valid;
    logic               o_ready;
    logic [1:0]         i_op;
    logic [KEY_W-1:0]   i_key;
    logic [VAL_W-1:0]   i_val;
    logic               o_valid;
    logic               o_hit;
    logic [VAL_W-1:0]   o_val;
    logic               o_err;
    logic [IDX_W:0]     o_count;
    logic               o_full;

    modport slave (
        input  i_valid, i_op, i_key, i_val,
        output o_ready, o_valid, o_hit, o_val, o_err, o_count, o_full
    );

    modport master (
        output i_valid, i_op, i_key, i_val,
        input  o_ready, o_valid, o_hit, o_val, o_err, o_count, o_full
    );
endinterface
`default_nettype wire

// File: rtl/scoreboard_hashmap.sv
`default_nettype none
// ============================================================================
// Module      : scoreboard_hashmap
// Description : Linear-probing key->value table tracking in-flight
//               cmd_id -> proc_id. One slot is examined per PROBE cycle;
//               deletes leave tombstones so probe chains stay intact.
//               Optional macro SB_CLEAR_EN enables op 11 (CLEAR).
// Revision    : 1.0 - initial release
// ============================================================================
module scoreboard_hashmap #(
    parameter int DEPTH = 8,
    parameter int KEY_W = 8,
    parameter int VAL_W = 3,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  wire logic            i_clk,
    input  wire logic            i_rst,
    scoreboard_hashmap_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROBE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [1:0] c_EMPTY  = 2'd0;
    localparam logic [1:0] c_VALID  = 2'd1;
    localparam logic [1:0] c_TOMB   = 2'd2;

    localparam logic [1:0] c_OP_LOOKUP = 2'b00;
    localparam logic [1:0] c_OP_INSERT = 2'b01;
    localparam logic [1:0] c_OP_DELETE = 2'b10;

    state_t             r_state;
    logic [1:0]         r_op;
    logic [KEY_W-1:0]   r_key;
    logic [VAL_W-1:0]   r_val;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_nprobe;
    logic               r_free_vld;
    logic [IDX_W-1:0]   r_free_idx;
    logic [IDX_W:0]     r_count;

    logic               r_rvalid;
    logic               r_hit;
    logic [VAL_W-1:0]   r_rval;
    logic               r_err;

    logic [1:0]         r_slot_st  [DEPTH];
    logic [KEY_W-1:0]   r_slot_key [DEPTH];
    logic [VAL_W-1:0]   r_slot_val [DEPTH];

    // Decode of the slot currently under the probe pointer
    logic               w_empty;
    logic               w_match;
    logic               w_last;
    logic               w_free_here;
    logic               w_have_free;
    logic [IDX_W-1:0]   w_free_idx;

    assign w_empty     = (r_slot_st[r_idx] == c_EMPTY);
    assign w_match     = (r_slot_st[r_idx] == c_VALID) && (r_slot_key[r_idx] == r_key);
    assign w_last      = (r_nprobe == IDX_W'(DEPTH - 1));
    assign w_free_here = (r_slot_st[r_idx] != c_VALID);
    assign w_have_free = r_free_vld || w_free_here;
    // Earliest free slot wins so inserts fill holes closest to the home index
    assign w_free_idx  = r_free_vld ? r_free_idx : r_idx;

    assign bus.o_ready = (r_state == S_IDLE) && !i_rst;
    assign bus.o_valid = r_rvalid;
    assign bus.o_hit   = r_hit;
    assign bus.o_val   = r_rval;
    assign bus.o_err   = r_err;
    assign bus.o_count = r_count;
    assign bus.o_full  = (r_count == (IDX_W+1)'(DEPTH));

    // Request FSM, probe walk, slot table and registered response
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_op       <= 2'b00;
            r_key      <= '0;
            r_val      <= '0;
            r_idx      <= '0;
            r_nprobe   <= '0;
            r_free_vld <= 1'b0;
            r_free_idx <= '0;
            r_count    <= '0;
            r_rvalid   <= 1'b0;
            r_hit      <= 1'b0;
            r_rval     <= '0;
            r_err      <= 1'b0;
            for (int s = 0; s < DEPTH; s++) begin
                r_slot_st[s] <= c_EMPTY;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_valid) begin
                        r_op       <= bus.i_op;
                        r_key      <= bus.i_key;
                        r_val      <= bus.i_val;
                        r_idx      <= bus.i_key[IDX_W-1:0];
                        r_nprobe   <= '0;
                        r_free_vld <= 1'b0;
                        r_state    <= S_PROBE;
                    end
                end
                S_PROBE: begin
                    r_idx    <= r_idx + IDX_W'(1);
                    r_nprobe <= r_nprobe + IDX_W'(1);
                    if (!r_free_vld && w_free_here) begin
                        r_free_vld <= 1'b1;
                        r_free_idx <= r_idx;
                    end
                    case (r_op)
                        c_OP_LOOKUP, c_OP_DELETE: begin
                            if (w_match) begin
                                r_hit    <= 1'b1;
                                r_rval   <= r_slot_val[r_idx];
                                r_rvalid <= 1'b1;
                                r_state  <= S_RESP;
                                if (r_op == c_OP_DELETE) begin
                                    r_slot_st[r_idx] <= c_TOMB;
                                    r_count          <= r_count - (IDX_W+1)'(1);
                                end
                            end else if (w_empty || w_last) begin
                                r_rvalid <= 1'b1;
                                r_state  <= S_RESP;
                            end
                        end
                        c_OP_INSERT: begin
                            if (w_match) begin
                                r_slot_val[r_idx] <= r_val;
                                r_hit             <= 1'b1;
                                r_rvalid          <= 1'b1;
                                r_state           <= S_RESP;
                            end else if (w_empty || w_last) begin
                                r_rvalid <= 1'b1;
                                r_state  <= S_RESP;
                                if (w_have_free) begin
                                    r_slot_st[w_free_idx]  <= c_VALID;
                                    r_slot_key[w_free_idx] <= r_key;
                                    r_slot_val[w_free_idx] <= r_val;
                                    r_count                <= r_count + (IDX_W+1)'(1);
                                end else begin
                                    r_err <= 1'b1;
                                end
                            end
                        end
                        default: begin
`ifdef SB_CLEAR_EN
                            for (int s = 0; s < DEPTH; s++) begin
                                r_slot_st[s] <= c_EMPTY;
                            end
                            r_count <= '0;
`else
                            r_err   <= 1'b1;
`endif
                            r_rvalid <= 1'b1;
                            r_state  <= S_RESP;
                        end
                    endcase
                end
                S_RESP: begin
                    r_rvalid <= 1'b0;
                    r_hit    <= 1'b0;
                    r_rval   <= '0;
                    r_err    <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_scoreboard_hashmap.sv
`default_nettype none
// ============================================================================
// Module      : tb_scoreboard_hashmap
// Description : Self-checking bench for scoreboard_hashmap (DEPTH=8, KEY_W=8,
//               VAL_W=3): directed scenarios followed by random traffic,
//               compared against a slot-level reference table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scoreboard_hashmap;
    localparam int DEPTH = 8;
    localparam int M_EMPTY = 0;
    localparam int M_VALID = 1;
    localparam int M_TOMB  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scoreboard_hashmap_if #(.DEPTH(8), .KEY_W(8), .VAL_W(3)) sb ();

    scoreboard_hashmap #(.DEPTH(8), .KEY_W(8), .VAL_W(3)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (sb)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference table
    int         m_st  [DEPTH];
    logic [7:0] m_key [DEPTH];
    logic [2:0] m_val [DEPTH];
    int         m_count;

    logic       last_hit;
    logic [2:0] last_val;
    logic       last_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < DEPTH; s++) m_st[s] = M_EMPTY;
        m_count = 0;
    endtask

    // Apply one operation to the reference table and return what the block should report
    task automatic model_op(input logic [1:0] op, input logic [7:0] key, input logic [2:0] val,
                            output logic e_hit, output logic [2:0] e_val, output logic e_err,
                            output int e_n);
        int i;
        int fr;
        bit done;
        e_hit = 0; e_val = 0; e_err = 0; e_n = DEPTH; fr = -1; done = 0;
        if (op == 2'b11) begin
            e_n = 1;
`ifdef SB_CLEAR_EN
            model_reset();
`else
            e_err = 1;
`endif
        end else begin
            for (int p = 0; p < DEPTH && !done; p++) begin
                i = (int'(key) + p) % DEPTH;
                if (op == 2'b01 && m_st[i] != M_VALID && fr < 0) fr = i;
                if (m_st[i] == M_VALID && m_key[i] == key) begin
                    e_n = p + 1; done = 1; e_hit = 1;
                    if (op == 2'b00) e_val = m_val[i];
                    else if (op == 2'b01) m_val[i] = val;
                    else begin
                        e_val = m_val[i];
                        m_st[i] = M_TOMB;
                        m_count--;
                    end
                end else if (m_st[i] == M_EMPTY) begin
                    e_n = p + 1; done = 1;
                end
            end
            if (op == 2'b01 && !e_hit) begin
                if (fr >= 0) begin
                    m_st[fr] = M_VALID; m_key[fr] = key; m_val[fr] = val;
                    m_count++;
                end else begin
                    e_err = 1;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sb.i_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("ready_in_reset", 32'(sb.o_ready), 0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("ready_after_reset", 32'(sb.o_ready), 1);
        chk("count_after_reset", 32'(sb.o_count), 0);
        chk("valid_after_reset", 32'(sb.o_valid), 0);
        chk("full_after_reset", 32'(sb.o_full), 0);
    endtask

    // Issue one request, wait for the response pulse and check it against the model
    task automatic do_op(input logic [1:0] op, input logic [7:0] key, input logic [2:0] val);
        logic e_hit; logic [2:0] e_val; logic e_err; int e_n; int lat; int wait_cyc;
        model_op(op, key, val, e_hit, e_val, e_err, e_n);
        @(negedge clk);
        wait_cyc = 0;
        while (!sb.o_ready && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        sb.i_valid = 1'b1; sb.i_op = op; sb.i_key = key; sb.i_val = val;
        lat = 0;
        do begin
            @(negedge clk);
            sb.i_valid = 1'b0;
            lat++;
        end while (!sb.o_valid && lat < 40);
        chk($sformatf("latency op%0d key%0d", op, key), 32'(lat), 32'(e_n + 1));
        chk($sformatf("hit op%0d key%0d", op, key), 32'(sb.o_hit), 32'(e_hit));
        chk($sformatf("val op%0d key%0d", op, key), 32'(sb.o_val), 32'(e_val));
        chk($sformatf("err op%0d key%0d", op, key), 32'(sb.o_err), 32'(e_err));
        chk($sformatf("count op%0d key%0d", op, key), 32'(sb.o_count), 32'(m_count));
        chk($sformatf("full op%0d key%0d", op, key), 32'(sb.o_full), 32'(m_count == DEPTH));
        last_hit = sb.o_hit; last_val = sb.o_val; last_err = sb.o_err;
        @(negedge clk);
        chk("valid_pulse_width", 32'(sb.o_valid), 0);
    endtask

    initial begin
        int quiet;
        sb.i_valid = 1'b0; sb.i_op = 2'b00; sb.i_key = '0; sb.i_val = '0;
        model_reset();
        do_reset();

        // Basic insert and lookup
        do_op(2'b01, 8'd3, 3'd5);
        chk("ins3_hit", 32'(last_hit), 0);
        do_op(2'b00, 8'd3, 3'd0);
        chk("lkp3_val", 32'(last_val), 5);

        // Collision chain across a tombstone
        do_op(2'b01, 8'd11, 3'd2);
        do_op(2'b10, 8'd3, 3'd0);
        chk("del3_val", 32'(last_val), 5);
        do_op(2'b00, 8'd11, 3'd0);
        chk("lkp11_val", 32'(last_val), 2);

        // Tombstone reuse, then update in place
        do_op(2'b01, 8'd19, 3'd6);
        do_op(2'b01, 8'd19, 3'd1);
        chk("upd19_hit", 32'(last_hit), 1);
        do_op(2'b00, 8'd19, 3'd0);
        chk("lkp19_val", 32'(last_val), 1);
        do_op(2'b10, 8'd77, 3'd0);

        // Full table: error on insert, bounded miss on lookup
        do_reset();
        for (int k = 0; k < 8; k++) do_op(2'b01, 8'(k), 3'(k));
        chk("full_flag", 32'(sb.o_full), 1);
        do_op(2'b01, 8'd8, 3'd4);
        chk("full_ins_err", 32'(last_err), 1);
        do_op(2'b00, 8'd8, 3'd0);
        do_op(2'b10, 8'd5, 3'd0);
        do_op(2'b01, 8'd13, 3'd7);
        do_op(2'b00, 8'd13, 3'd0);

        // Reset while an insert is probing: the response must never appear
        do_reset();
        @(negedge clk);
        sb.i_valid = 1'b1; sb.i_op = 2'b01; sb.i_key = 8'd42; sb.i_val = 3'd3;
        @(negedge clk);
        sb.i_valid = 1'b0;
        rst = 1'b1;
        quiet = 1;
        repeat (3) begin
            @(negedge clk);
            if (sb.o_valid !== 1'b0) quiet = 0;
        end
        chk("abort_no_valid", 32'(quiet), 1);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("abort_count", 32'(sb.o_count), 0);
        do_op(2'b00, 8'd42, 3'd0);
        chk("abort_lkp_miss", 32'(last_hit), 0);

        // Op 11 on a table holding three entries
        do_op(2'b01, 8'd1, 3'd1);
        do_op(2'b01, 8'd9, 3'd2);
        do_op(2'b01, 8'd30, 3'd3);
        do_op(2'b11, 8'd0, 3'd0);
        do_op(2'b00, 8'd1, 3'd0);
        do_op(2'b00, 8'd9, 3'd0);
        do_op(2'b00, 8'd30, 3'd0);

        // Random traffic over a small key space to force collisions and tombstones
        do_reset();
        for (int t = 0; t < 150; t++) begin
            int sel;
            logic [1:0] op;
            sel = int'($urandom_range(0, 29));
            if (sel < 10)      op = 2'b00;
            else if (sel < 20) op = 2'b01;
            else if (sel < 29) op = 2'b10;
            else               op = 2'b11;
            do_op(op, 8'($urandom_range(0, 23)), 3'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
